hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage RV32I core.
- Sequences the F/D, D/E, E/M and M/W pipeline registers through stall and flush controls, including the D/E register's flushE input.
- Generates the E-stage forwarding selects.
- Contains a small FSM that freezes the pipeline while data memory is not ready, with a watchdog timeout.

---
 rtl/hazard_ctrl.sv | 143 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I pipeline: stall/flush sequencing, E-stage forwarding, data-memory wait FSM.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
  parameter int WIDTH       = 32,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1D,
  input  logic [4:0]       rs2D,
  input  logic [4:0]       rs1E,
  input  logic [4:0]       rs2E,
  input  logic [4:0]       rdE,
  input  logic [4:0]       rdM,
  input  logic [4:0]       rdW,
  input  logic [1:0]       resultsrcE,
  input  logic             regwriteM,
  input  logic             regwriteW,
  input  logic             pcsrcE,
  input  logic             memreqM,
  input  logic             memreadyM,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushD,
  output logic             flushE,
  output logic             flushW,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             memerr,
  output logic [WIDTH-1:0] stall_cycles,
  output logic [WIDTH-1:0] flush_count
);

  localparam int CW = $clog2(MEM_TIMEOUT) + 1;

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t        state, state_d;
  logic [CW-1:0] wait_cnt, wait_cnt_d;
  logic          loaduse, memstall, timeout, hold;

  assign loaduse  = (resultsrcE == 2'b01) && (rdE != 5'd0) && ((rdE == rs1D) || (rdE == rs2D));
  assign memstall = memreqM && !memreadyM;
  assign timeout  = (state == MEM_WAIT) && (wait_cnt == CW'(MEM_TIMEOUT)) && !memreadyM;
  assign hold     = (state == MEM_WAIT) && !memreadyM && !timeout;

  // M stage has priority over W; x0 is never forwarded.
  always_comb begin
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    if (regwriteM && (rdM != 5'd0) && (rdM == rs1E))      forwardAE = 2'b10;
    else if (regwriteW && (rdW != 5'd0) && (rdW == rs1E)) forwardAE = 2'b01;
    if (regwriteM && (rdM != 5'd0) && (rdM == rs2E))      forwardBE = 2'b10;
    else if (regwriteW && (rdW != 5'd0) && (rdW == rs2E)) forwardBE = 2'b01;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_d;
      wait_cnt <= wait_cnt_d;
    end
  end

  // The wait counter saturates at MEM_TIMEOUT, where the watchdog forces an exit.
  always_comb begin
    state_d    = state;
    wait_cnt_d = wait_cnt;
    case (state)
      RUN: begin
        if (memstall) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = CW'(1);
        end
      end
      MEM_WAIT: begin
        if (memreadyM || timeout) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt != CW'(MEM_TIMEOUT)) begin
          wait_cnt_d = wait_cnt + 1'b1;
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Outputs are forced low during reset so a pending memstall cannot leak through.
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    flushW = 1'b0;
    memerr = rst_n && timeout;
    if (rst_n) begin
      if (((state == RUN) && memstall) || hold) begin
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        stallM = 1'b1;
        flushW = 1'b1;
      end else if (pcsrcE) begin
        flushD = 1'b1;
        flushE = 1'b1;
      end else if (loaduse) begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [WIDTH-1:0] stall_q, flush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stallF)           stall_q <= stall_q + 1'b1;
      if (flushD || flushE) flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl with MEM_TIMEOUT=4; expected values are hand-computed.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic [1:0]  resultsrcE;
  logic        regwriteM, regwriteW, pcsrcE, memreqM, memreadyM;
  logic        stallF, stallD, stallE, stallM, flushD, flushE, flushW, memerr;
  logic [1:0]  forwardAE, forwardBE;
  logic [31:0] stall_cycles, flush_count;
  logic [6:0]  ctl;

  int numChecks = 0;
  int numErrors = 0;

  localparam logic [6:0] CTL_NONE  = 7'b0000000;
  localparam logic [6:0] CTL_LU    = 7'b1100010;
  localparam logic [6:0] CTL_REDIR = 7'b0000110;
  localparam logic [6:0] CTL_MEM   = 7'b1111001;

  assign ctl = {stallF, stallD, stallE, stallM, flushD, flushE, flushW};

  always #5 clk = ~clk;

  hazard_ctrl #(.WIDTH(32), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .rdM(rdM), .rdW(rdW), .resultsrcE(resultsrcE),
    .regwriteM(regwriteM), .regwriteW(regwriteW), .pcsrcE(pcsrcE),
    .memreqM(memreqM), .memreadyM(memreadyM),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushW(flushW),
    .forwardAE(forwardAE), .forwardBE(forwardBE), .memerr(memerr),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    numChecks++;
    if (observed !== expected) begin
      numErrors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] eRd, input logic [4:0] dRs1, input logic [4:0] dRs2,
                               input logic [1:0] eSrc, input logic pc, input logic req, input logic rdy);
    rdE        = eRd;
    rs1D       = dRs1;
    rs2D       = dRs2;
    resultsrcE = eSrc;
    pcsrcE     = pc;
    memreqM    = req;
    memreadyM  = rdy;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
    resultsrcE = 2'b00; regwriteM = 0; regwriteW = 0;
    rst_n = 1'b0; pcsrcE = 1'b1; memreqM = 1'b1; memreadyM = 1'b0;
    #2;
    checkOutput("rst_ctl", 32'(ctl), 32'(CTL_NONE));
    checkOutput("rst_memerr", 32'(memerr), 32'd0);
    checkOutput("rst_stallcnt", stall_cycles, 32'd0);
    checkOutput("rst_flushcnt", flush_count, 32'd0);
    #5;
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 2'b00, 0, 0, 1);
    checkOutput("idle", 32'(ctl), 32'(CTL_NONE));
    tick();

    // Forwarding
    rdM = 5; rdW = 5; regwriteM = 1; regwriteW = 1; rs1E = 5; rs2E = 5; #1;
    checkOutput("fwdA_M", 32'(forwardAE), 32'd2);
    checkOutput("fwdB_M", 32'(forwardBE), 32'd2);
    regwriteM = 0; #1;
    checkOutput("fwdA_W", 32'(forwardAE), 32'd1);
    rs2E = 6; #1;
    checkOutput("fwdB_none", 32'(forwardBE), 32'd0);
    rdM = 0; rdW = 0; regwriteM = 1; rs1E = 0; rs2E = 0; #1;
    checkOutput("fwdA_x0", 32'(forwardAE), 32'd0);
    checkOutput("fwdB_x0", 32'(forwardBE), 32'd0);
    rdM = 4; rdW = 9; rs1E = 9; rs2E = 4; #1;
    checkOutput("fwdA_W_split", 32'(forwardAE), 32'd1);
    checkOutput("fwdB_M_split", 32'(forwardBE), 32'd2);
    rdM = 0; rdW = 0; regwriteM = 0; regwriteW = 0; rs1E = 0; rs2E = 0;

    // Load-use, redirect priority and perf-counter events
    applyStimulus(7, 0, 7, 2'b01, 0, 0, 1);
    checkOutput("lu1", 32'(ctl), 32'(CTL_LU));
    tick();
    applyStimulus(3, 0, 7, 2'b00, 0, 0, 1);
    checkOutput("lu1_clear", 32'(ctl), 32'(CTL_NONE));
    tick();
    applyStimulus(9, 9, 0, 2'b01, 0, 0, 1);
    checkOutput("lu2_rs1", 32'(ctl), 32'(CTL_LU));
    tick();
    applyStimulus(0, 0, 0, 2'b01, 0, 0, 1);
    checkOutput("lu_x0", 32'(ctl), 32'(CTL_NONE));
    tick();
    applyStimulus(7, 0, 7, 2'b00, 0, 0, 1);
    checkOutput("lu_noload", 32'(ctl), 32'(CTL_NONE));
    tick();
    applyStimulus(7, 7, 0, 2'b01, 1, 0, 1);
    checkOutput("redir_lu", 32'(ctl), 32'(CTL_REDIR));
    tick();
    applyStimulus(0, 0, 0, 2'b00, 1, 0, 1);
    checkOutput("redir", 32'(ctl), 32'(CTL_REDIR));
    tick();
    applyStimulus(12, 0, 12, 2'b01, 0, 0, 1);
    checkOutput("lu3", 32'(ctl), 32'(CTL_LU));
    tick();
    applyStimulus(0, 0, 0, 2'b00, 0, 0, 1);
    checkOutput("post_events", 32'(ctl), 32'(CTL_NONE));
`ifdef HAZARD_PERF_EN
    checkOutput("perf_stall", stall_cycles, 32'd3);
    checkOutput("perf_flush", flush_count, 32'd5);
`else
    checkOutput("perf_stall_off", stall_cycles, 32'd0);
    checkOutput("perf_flush_off", flush_count, 32'd0);
`endif
    tick();

    // Memory wait released by memreadyM
    applyStimulus(0, 0, 0, 2'b00, 0, 1, 0);
    checkOutput("mw1", 32'(ctl), 32'(CTL_MEM));
    checkOutput("mw1_memerr", 32'(memerr), 32'd0);
    tick();
    applyStimulus(0, 0, 0, 2'b00, 1, 1, 0);
    checkOutput("mw2_pc_ignored", 32'(ctl), 32'(CTL_MEM));
    tick();
    applyStimulus(0, 0, 0, 2'b00, 0, 1, 0);
    checkOutput("mw3", 32'(ctl), 32'(CTL_MEM));
    tick();
    applyStimulus(0, 0, 0, 2'b00, 0, 1, 1);
    checkOutput("mw_exit", 32'(ctl), 32'(CTL_NONE));
    tick();
    applyStimulus(0, 0, 0, 2'b00, 0, 0, 0);
    checkOutput("mw_back_run", 32'(ctl), 32'(CTL_NONE));
    tick();
    applyStimulus(0, 0, 0, 2'b00, 0, 1, 0);
    checkOutput("mw_b1", 32'(ctl), 32'(CTL_MEM));
    tick();
    applyStimulus(0, 0, 0, 2'b00, 1, 1, 1);
    checkOutput("mw_exit_pc", 32'(ctl), 32'(CTL_REDIR));
    tick();

    // Watchdog timeout (MEM_TIMEOUT=4)
    applyStimulus(0, 0, 0, 2'b00, 0, 1, 0);
    checkOutput("to_enter", 32'(ctl), 32'(CTL_MEM));
    tick();
    for (int i = 1; i <= 3; i++) begin
      #2;
      checkOutput($sformatf("to_wait%0d", i), 32'(ctl), 32'(CTL_MEM));
      checkOutput($sformatf("to_memerr%0d", i), 32'(memerr), 32'd0);
      tick();
    end
    #2;
    checkOutput("to_memerr", 32'(memerr), 32'd1);
    checkOutput("to_release", 32'(ctl), 32'(CTL_NONE));
    tick();
    #2;
    checkOutput("to_rearm", 32'(ctl), 32'(CTL_MEM));
    checkOutput("to_pulse_once", 32'(memerr), 32'd0);
    tick();
    #2;
    checkOutput("to_wait_again", 32'(ctl), 32'(CTL_MEM));
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_ctl", 32'(ctl), 32'(CTL_NONE));
    checkOutput("rst_mid_memerr", 32'(memerr), 32'd0);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 2'b00, 0, 0, 0);
    checkOutput("post_rst", 32'(ctl), 32'(CTL_NONE));
    tick();
    #2;
    checkOutput("post_rst_run", 32'(ctl), 32'(CTL_NONE));

    $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
    $finish;
  end

endmodule
